// File: rtl/viterbi_pkg.sv
// Shared Viterbi front-end definitions: code-rate encodings, slicer states
// and the default width of the sliced-symbol bus.
package viterbi_pkg;

  localparam logic CODE_RATE_2 = 1'b0;
  localparam logic CODE_RATE_3 = 1'b1;

  localparam int SYM_PER_CYC_DEF  = 2;
  localparam int MAX_N_DEF        = 3;
  localparam int SLICED_INPUT_NUM = SYM_PER_CYC_DEF * MAX_N_DEF;

  typedef enum logic {
    IDLE,
    STREAM
  } slicer_state_t;

  function automatic int sliced_input_num(input int symPerCyc, input int maxN);
    return symPerCyc * maxN;
  endfunction

endpackage

// File: rtl/frame_slicer_lane.sv
// Extracts one lane of N code bits from the held frame, starting at the
// current read pointer offset by this lane's position within the beat.
module frame_slicer_lane
  import viterbi_pkg::*;
#(
  parameter int FRAME_W = 276,
  parameter int MAX_N   = 3,
  parameter int PTR_W   = 9,
  parameter int LANE    = 0
) (
  input  logic [FRAME_W-1:0] frame_i,
  input  logic [PTR_W-1:0]   ptr_i,
  input  logic               rate_i,
  input  logic               valid_i,
  output logic [MAX_N-1:0]   lane_o
);

  int n;
  int idx;

  always_comb begin
    lane_o = '0;
    n      = (rate_i == CODE_RATE_3) ? 3 : 2;
    idx    = 0;
    for (int j = 0; j < MAX_N; j++) begin
      idx = int'(ptr_i) - LANE * n - j;
      // Bits beyond the code rate, and any position below bit 0, stay zero.
      if (valid_i && (j < n) && (idx >= 0) && (idx < FRAME_W)) begin
        lane_o[j] = frame_i[idx[PTR_W-1:0]];
      end
    end
  end

endmodule

// File: rtl/frame_slicer.sv
// Frame slicer: holds one code frame and streams SYM_PER_CYC symbols per beat.
// Optional beat/stall counters are built when SLICE_PERF_EN is defined.
module frame_slicer
  import viterbi_pkg::*;
#(
  parameter int FRAME_W     = 276,
  parameter int SYM_PER_CYC = 2,
  parameter int MAX_N       = 3,
  parameter int CNT_W       = $clog2(FRAME_W/2+1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_load,
  output logic                         o_load_ready,
  input  logic [FRAME_W-1:0]           i_data_frame,
  input  logic                         i_code_rate,
  input  logic [CNT_W-1:0]             i_sym_cnt,
  input  logic                         i_eof,
  output logic [SYM_PER_CYC*MAX_N-1:0] o_rx,
  output logic [SYM_PER_CYC-1:0]       o_lane_valid,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic                         o_last,
`ifdef SLICE_PERF_EN
  output logic [15:0]                  o_beat_cnt,
  output logic [15:0]                  o_stall_cnt,
`endif
  output logic                         o_ood
);

  localparam int PTR_W = $clog2(FRAME_W);
  localparam logic [CNT_W-1:0] MAXSYM2 = CNT_W'(FRAME_W / 2);
  localparam logic [CNT_W-1:0] MAXSYM3 = CNT_W'(FRAME_W / 3);
  localparam logic [CNT_W-1:0] SPC_C   = CNT_W'(SYM_PER_CYC);
  localparam logic [PTR_W-1:0] STEP2   = PTR_W'(SYM_PER_CYC * 2);
  localparam logic [PTR_W-1:0] STEP3   = PTR_W'(SYM_PER_CYC * 3);
  localparam logic [PTR_W-1:0] PTR_TOP = PTR_W'(FRAME_W - 1);

  slicer_state_t      state_q, state_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               rate_q, rate_d;
  logic               eof_q, eof_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [CNT_W-1:0]   maxSym;
  logic               beatAcc;
  logic               loadAcc;

  assign o_valid      = (state_q == STREAM);
  assign o_last       = o_valid & (rem_q <= SPC_C);
  assign o_ood        = o_last & eof_q;
  assign beatAcc      = o_valid & i_ready;
  assign o_load_ready = (state_q == IDLE) | (beatAcc & o_last);
  assign loadAcc      = i_load & o_load_ready;
  assign maxSym       = (i_code_rate == CODE_RATE_3) ? MAXSYM3 : MAXSYM2;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      frame_q <= '0;
      rate_q  <= CODE_RATE_2;
      eof_q   <= 1'b0;
      ptr_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      rate_q  <= rate_d;
      eof_q   <= eof_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
    end
  end

  // A load on the last accepted beat takes priority so the stream continues without a bubble.
  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    rate_d  = rate_q;
    eof_d   = eof_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    if (loadAcc) begin
      state_d = STREAM;
      frame_d = i_data_frame;
      rate_d  = i_code_rate;
      eof_d   = i_eof;
      ptr_d   = PTR_TOP;
      rem_d   = ((i_sym_cnt == '0) || (i_sym_cnt > maxSym)) ? maxSym : i_sym_cnt;
    end else if (beatAcc) begin
      ptr_d = ptr_q - ((rate_q == CODE_RATE_3) ? STEP3 : STEP2);
      rem_d = o_last ? '0 : (rem_q - SPC_C);
      if (o_last) begin
        state_d = IDLE;
      end
    end
  end

  for (genvar s = 0; s < SYM_PER_CYC; s++) begin : g_lane
    assign o_lane_valid[s] = o_valid & (rem_q > CNT_W'(s));

    frame_slicer_lane #(
      .FRAME_W(FRAME_W),
      .MAX_N  (MAX_N),
      .PTR_W  (PTR_W),
      .LANE   (s)
    ) u_lane (
      .frame_i(frame_q),
      .ptr_i  (ptr_q),
      .rate_i (rate_q),
      .valid_i(o_lane_valid[s]),
      .lane_o (o_rx[s*MAX_N +: MAX_N])
    );
  end

`ifdef SLICE_PERF_EN
  logic [15:0] beat_cnt_q, stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (beatAcc && (beat_cnt_q != 16'hFFFF)) begin
        beat_cnt_q <= beat_cnt_q + 16'd1;
      end
      if (o_valid && !i_ready && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
    end
  end

  assign o_beat_cnt  = beat_cnt_q;
  assign o_stall_cnt = stall_cnt_q;
`else
  // Counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_frame_slicer.sv
// Scoreboard bench for frame_slicer: stimulus pushes expected beats, a negedge
// monitor pops and checks them; counter checks added when SLICE_PERF_EN is set.
module tb_frame_slicer;
  import viterbi_pkg::*;

  localparam int FRAME_W = 276;
  localparam int SPC     = 2;
  localparam int MAX_N   = 3;
  localparam int CNT_W   = $clog2(FRAME_W/2+1);
  localparam int RXW     = SPC * MAX_N;

  typedef struct packed {
    logic [RXW-1:0] rx;
    logic [SPC-1:0] laneValid;
    logic           last;
    logic           ood;
  } beat_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               i_load;
  logic               o_load_ready;
  logic [FRAME_W-1:0] i_data_frame;
  logic               i_code_rate;
  logic [CNT_W-1:0]   i_sym_cnt;
  logic               i_eof;
  logic [RXW-1:0]     o_rx;
  logic [SPC-1:0]     o_lane_valid;
  logic               o_valid;
  logic               i_ready;
  logic               o_last;
  logic               o_ood;
`ifdef SLICE_PERF_EN
  logic [15:0]        o_beat_cnt;
  logic [15:0]        o_stall_cnt;
`endif

  beat_t expQ[$];
  int nCompared   = 0;
  int nMismatched = 0;

  logic [FRAME_W-1:0] frameA;
  logic [FRAME_W-1:0] frameB;
  logic [FRAME_W-1:0] frameC;

  always #5 clk = ~clk;

  frame_slicer #(
    .FRAME_W    (FRAME_W),
    .SYM_PER_CYC(SPC),
    .MAX_N      (MAX_N),
    .CNT_W      (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_load      (i_load),
    .o_load_ready(o_load_ready),
    .i_data_frame(i_data_frame),
    .i_code_rate (i_code_rate),
    .i_sym_cnt   (i_sym_cnt),
    .i_eof       (i_eof),
    .o_rx        (o_rx),
    .o_lane_valid(o_lane_valid),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_last      (o_last),
`ifdef SLICE_PERF_EN
    .o_beat_cnt  (o_beat_cnt),
    .o_stall_cnt (o_stall_cnt),
`endif
    .o_ood       (o_ood)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected beats come from the bit positions of each symbol in the frame.
  function automatic void pushFrame(input logic [FRAME_W-1:0] f, input int n, input int tot,
                                    input logic eof);
    beat_t e;
    int nb;
    int remB;
    logic [FRAME_W-1:0] sh;
    nb = (tot + SPC - 1) / SPC;
    for (int b = 0; b < nb; b++) begin
      e    = '0;
      remB = tot - b * SPC;
      for (int s = 0; s < SPC; s++) begin
        if (s < remB) begin
          e.laneValid = e.laneValid | (SPC'(1) << s);
          for (int j = 0; j < n; j++) begin
            sh   = f << ((b * SPC + s) * n + j);
            e.rx = e.rx | (RXW'(sh[FRAME_W-1]) << (s * MAX_N + j));
          end
        end
      end
      e.last = (remB <= SPC);
      e.ood  = e.last & eof;
      expQ.push_back(e);
    end
  endfunction

  task automatic applyStimulus(input logic [FRAME_W-1:0] f, input logic rate, input int cnt,
                               input logic eof, output int waited);
    int n;
    int maxSym;
    int tot;
    logic accepted;
    n      = rate ? 3 : 2;
    maxSym = FRAME_W / n;
    tot    = ((cnt == 0) || (cnt > maxSym)) ? maxSym : cnt;
    pushFrame(f, n, tot, eof);
    i_load       = 1'b1;
    i_data_frame = f;
    i_code_rate  = rate;
    i_sym_cnt    = CNT_W'(cnt);
    i_eof        = eof;
    accepted     = 1'b0;
    waited       = 0;
    while (!accepted && waited < 1000) begin
      @(negedge clk);
      accepted = o_load_ready;
      @(posedge clk);
      #1;
      waited++;
    end
    i_load       = 1'b0;
    i_data_frame = ~f;
    i_code_rate  = ~rate;
    i_sym_cnt    = CNT_W'(1);
    i_eof        = ~eof;
    if (!accepted) begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL load_timeout: got no accept, expected o_load_ready");
    end
  endtask

  task automatic waitDrain(input string name);
    int guard;
    guard = 0;
    while (expQ.size() != 0 && guard < 2000) begin
      @(posedge clk);
      guard++;
    end
    #1;
    if (expQ.size() != 0) begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL %s_drain: got %0d beats left, expected 0", name, expQ.size());
      expQ.delete();
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: accepted beats pop the scoreboard, stalled beats must match the head unchanged.
  always @(negedge clk) begin : monitor
    beat_t e;
    if (!rst) begin
      if (o_valid) begin
        if (expQ.size() == 0) begin
          nCompared++;
          nMismatched++;
          $display("[TB] FAIL unexpected_beat: got rx=0x%0h, expected no beat", o_rx);
        end else begin
          e = i_ready ? expQ.pop_front() : expQ[0];
          checkOutput(i_ready ? "beat_rx" : "stall_rx", 32'(o_rx), 32'(e.rx));
          checkOutput(i_ready ? "beat_lane_valid" : "stall_lane_valid",
                      32'(o_lane_valid), 32'(e.laneValid));
          checkOutput(i_ready ? "beat_last" : "stall_last", 32'(o_last), 32'(e.last));
          checkOutput(i_ready ? "beat_ood" : "stall_ood", 32'(o_ood), 32'(e.ood));
        end
      end else begin
        checkOutput("idle_rx", 32'(o_rx), 32'd0);
        checkOutput("idle_last_ood", {30'd0, o_last, o_ood}, 32'd0);
      end
    end
  end

  initial begin
    int waited;
    frameA       = {4'b1011, {34{8'hA5}}};
    frameB       = {6'b110100, {30{9'h15B}}};
    frameC       = {69{4'h6}};
    rst          = 1'b1;
    i_load       = 1'b0;
    i_data_frame = '0;
    i_code_rate  = CODE_RATE_2;
    i_sym_cnt    = '0;
    i_eof        = 1'b0;
    i_ready      = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] reset state");
    checkOutput("rst_valid", 32'(o_valid), 32'd0);
    checkOutput("rst_load_ready", 32'(o_load_ready), 32'd1);
    checkOutput("rst_rx", 32'(o_rx), 32'd0);
    checkOutput("rst_lane_valid", 32'(o_lane_valid), 32'd0);
    checkOutput("rst_last_ood", {30'd0, o_last, o_ood}, 32'd0);

    $display("[TB] rate 1/2 full frame");
    applyStimulus(frameA, CODE_RATE_2, 0, 1'b0, waited);
    checkOutput("r2_beat1_rx", 32'(o_rx), 32'h19);
    checkOutput("r2_beat1_lane_valid", 32'(o_lane_valid), 32'd3);
    waitDrain("r2_full");
    checkOutput("r2_idle_valid", 32'(o_valid), 32'd0);

    $display("[TB] rate 1/3 full frame with eof");
    applyStimulus(frameB, CODE_RATE_3, 0, 1'b1, waited);
    checkOutput("r3_beat1_rx", 32'(o_rx), 32'h0B);
    waitDrain("r3_eof");
    checkOutput("r3_idle_valid", 32'(o_valid), 32'd0);
    checkOutput("r3_idle_load_ready", 32'(o_load_ready), 32'd1);

    $display("[TB] rate 1/2 partial frame of 5 symbols");
    applyStimulus(frameC, CODE_RATE_2, 5, 1'b0, waited);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    checkOutput("tail_lane_valid", 32'(o_lane_valid), 32'd1);
    checkOutput("tail_last", 32'(o_last), 32'd1);
    checkOutput("tail_rx", 32'(o_rx), 32'h02);
    waitDrain("tail");

    $display("[TB] stall pattern 1,0,0,1");
    doReset();
    applyStimulus(frameA, CODE_RATE_2, 10, 1'b0, waited);
    @(posedge clk);
    #1;
    i_ready = 1'b0;
    checkOutput("stall_load_ready", 32'(o_load_ready), 32'd0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    i_ready = 1'b1;
    waitDrain("stall");
`ifdef SLICE_PERF_EN
    checkOutput("perf_stall_cnt", 32'(o_stall_cnt), 32'd2);
    checkOutput("perf_beat_cnt", 32'(o_beat_cnt), 32'd5);
`endif

    $display("[TB] back-to-back loads");
    applyStimulus(frameC, CODE_RATE_2, 5, 1'b0, waited);
    applyStimulus(frameA, CODE_RATE_3, 4, 1'b1, waited);
    checkOutput("b2b_wait", 32'(waited), 32'd3);
    checkOutput("b2b_valid", 32'(o_valid), 32'd1);
    waitDrain("b2b");

    $display("[TB] reset during beat 10");
    applyStimulus(frameA, CODE_RATE_2, 0, 1'b0, waited);
    repeat (9) @(posedge clk);
    #1;
    doReset();
    expQ.delete();
    checkOutput("midrst_valid", 32'(o_valid), 32'd0);
    checkOutput("midrst_load_ready", 32'(o_load_ready), 32'd1);
    checkOutput("midrst_lane_valid", 32'(o_lane_valid), 32'd0);
    applyStimulus(frameB, CODE_RATE_2, 0, 1'b0, waited);
    checkOutput("midrst_restart_rx", 32'(o_rx), 32'h13);
    waitDrain("midrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
